conv328: RTL and testbench

- Parallel-to-byte down-converter: the transmit-side counterpart of the 8-to-32 packer (conv832).
- Accepts one word of 32, 16 or 8 valid bits, selected by PCLK, and emits it as a stream of bytes on an 8-bit lane.
- Uses a valid/ready handshake on both sides, with back-to-back word acceptance.
- Sits between the PHY parallel interface and the byte-wide serializer path.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv328.sv | 101 ++++++++++
 tb/tb_conv328.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv832 packer and the conv328 down-converter.
package conv_pkg;

  localparam logic [1:0] MODE_32 = 2'b00;
  localparam logic [1:0] MODE_16 = 2'b01;
  localparam logic [1:0] MODE_8  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } conv_state_t;

  // Bytes carried by one word in the given mode; the reserved code behaves as 8-bit.
  function automatic logic [2:0] nbytes(input logic [1:0] mode);
    case (mode)
      MODE_32: nbytes = 3'd4;
      MODE_16: nbytes = 3'd2;
      default: nbytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/conv328.sv
// 32/16/8-bit word to byte-stream down-converter; first byte 1 cycle after accept, one byte/cycle, MSB first.
// Stalls hold all state; in_ready is combinational from out_ready. Optional out_par under CONV328_PARITY_EN.
module conv328
  import conv_pkg::*;
#(
  parameter int DW = 32,
  parameter int BW = 8
) (
  input  logic          CLK,
  input  logic          ENB,
  input  logic [1:0]    PCLK,
  input  logic [DW-1:0] in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] out,
  output logic          out_valid,
`ifdef CONV328_PARITY_EN
  output logic          out_par,
`endif
  input  logic          out_ready
);

  conv_state_t   state;
  logic [DW-1:0] sr;
  logic [1:0]    mode_q;
  logic [1:0]    pos;

  logic [2:0]    nb_q;
  logic          last;
  logic          accept;
  logic [BW-1:0] first_byte;
  logic [1:0]    nxt_pos;
  logic [BW-1:0] nxt_byte;

  // pos counts bytes already presented; the word ends when it reaches nbytes-1.
  assign nb_q     = nbytes(mode_q);
  assign last     = ({1'b0, pos} == (nb_q - 3'd1));
  assign in_ready = ENB & (~out_valid | (last & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    case (PCLK)
      MODE_32: first_byte = in[31:24];
      MODE_16: first_byte = in[15:8];
      default: first_byte = in[7:0];
    endcase
  end

  // Byte lane index of the next byte within the raw word, counted from bit 0.
  assign nxt_pos  = nb_q[1:0] - 2'd2 - pos;
  assign nxt_byte = sr[{nxt_pos, 3'b000} +: BW];

  always_ff @(posedge CLK or negedge ENB) begin
    if (!ENB) begin
      state     <= ST_IDLE;
      sr        <= '0;
      mode_q    <= MODE_8;
      pos       <= 2'd0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef CONV328_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (accept) begin
      state     <= ST_SEND;
      sr        <= in;
      mode_q    <= PCLK;
      pos       <= 2'd0;
      out       <= first_byte;
      out_valid <= 1'b1;
`ifdef CONV328_PARITY_EN
      out_par   <= ^first_byte;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
        end
        ST_SEND: begin
          if (out_ready) begin
            if (last) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end else begin
              pos       <= pos + 2'd1;
              out       <= nxt_byte;
`ifdef CONV328_PARITY_EN
              out_par   <= ^nxt_byte;
`endif
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv328.sv
// Directed bench for conv328: reset, all modes, back-to-back words, backpressure, mid-word reset.
module tb_conv328;

  logic        CLK = 1'b0;
  logic        ENB;
  logic [1:0]  PCLK;
  logic [31:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dout;
  logic        out_valid;
  logic        out_ready;
`ifdef CONV328_PARITY_EN
  logic        out_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  conv328 dut (
    .CLK       (CLK),
    .ENB       (ENB),
    .PCLK      (PCLK),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
`ifdef CONV328_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: inputs set after this returns are sampled at the next rising edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic put(input logic [1:0] mode, input logic [31:0] word);
    PCLK     = mode;
    din      = word;
    in_valid = 1'b1;
  endtask

  task automatic byte_is(input string tag, input logic [7:0] b);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_dat"}, {24'd0, dout}, {24'd0, b});
  endtask

  initial begin
    ENB = 1'b0; PCLK = 2'b00; din = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd0);
    check("rst_dat", {24'd0, dout}, 32'h00);
`ifdef CONV328_PARITY_EN
    check("rst_par", {31'd0, out_par}, 32'd0);
`endif

    // 32-bit word, then 16-bit and 8-bit words with no gaps
    ENB = 1'b1;
    put(2'b00, 32'h0FF0AA50);
    #1 check("idle_rdy", {31'd0, in_ready}, 32'd1);
    step(); in_valid = 1'b0;
    byte_is("w32_b0", 8'h0F);
`ifdef CONV328_PARITY_EN
    check("par_0f", {31'd0, out_par}, 32'd0);
`endif
    check("w32_b0_rdy", {31'd0, in_ready}, 32'd0);
    step(); byte_is("w32_b1", 8'hF0);
    check("w32_b1_rdy", {31'd0, in_ready}, 32'd0);
    step(); byte_is("w32_b2", 8'hAA);
    check("w32_b2_rdy", {31'd0, in_ready}, 32'd0);
    step(); byte_is("w32_b3", 8'h50);
    check("w32_b3_rdy", {31'd0, in_ready}, 32'd1);
    put(2'b01, 32'hABCD7010);
    step(); in_valid = 1'b0;
    byte_is("w16_b0", 8'h70);
    check("w16_b0_rdy", {31'd0, in_ready}, 32'd0);
    step(); byte_is("w16_b1", 8'h10);
    check("w16_b1_rdy", {31'd0, in_ready}, 32'd1);
    put(2'b10, 32'hFFFFFFD0);
    step(); in_valid = 1'b0;
    byte_is("w8_b0", 8'hD0);
    step();
    check("w8_end_vld", {31'd0, out_valid}, 32'd0);

    // Backpressure on the second byte
    put(2'b00, 32'h11223344);
    step(); in_valid = 1'b0;
    byte_is("bp_b0", 8'h11);
    step(); byte_is("bp_b1", 8'h22);
    out_ready = 1'b0;
    #1 check("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      din = 32'h99999999; PCLK = 2'b10;
      step(); byte_is("bp_hold", 8'h22);
    end
    out_ready = 1'b1;
    step(); byte_is("bp_b2", 8'h33);
    step(); byte_is("bp_b3", 8'h44);
    step();
    check("bp_end_vld", {31'd0, out_valid}, 32'd0);

    // Reserved mode acts as 8-bit
    put(2'b11, 32'h000000AE);
    step(); in_valid = 1'b0;
    byte_is("rsv_b0", 8'hAE);
    check("rsv_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check("rsv_end_vld", {31'd0, out_valid}, 32'd0);

    // Mode change mid-word keeps four bytes
    put(2'b00, 32'hA1B2C3D4);
    step(); in_valid = 1'b0;
    PCLK = 2'b10; din = 32'h00000077;
    byte_is("mc_b0", 8'hA1);
    step(); byte_is("mc_b1", 8'hB2);
    check("mc_b1_rdy", {31'd0, in_ready}, 32'd0);
    PCLK = 2'b01;
    step(); byte_is("mc_b2", 8'hC3);
    step(); byte_is("mc_b3", 8'hD4);
    step();
    check("mc_end_vld", {31'd0, out_valid}, 32'd0);

`ifdef CONV328_PARITY_EN
    put(2'b10, 32'h00000007);
    step(); in_valid = 1'b0;
    byte_is("par_b", 8'h07);
    check("par_07", {31'd0, out_par}, 32'd1);
    step();
`endif

    // Reset mid-word discards the remainder
    put(2'b00, 32'h55667788);
    step(); in_valid = 1'b0;
    byte_is("mr_b0", 8'h55);
    #2 ENB = 1'b0;
    #1;
    check("mr_vld", {31'd0, out_valid}, 32'd0);
    check("mr_dat", {24'd0, dout}, 32'h00);
    check("mr_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge CLK); #1 ENB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_quiet", {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
